vga_face_cfg_sched: RTL and testbench

- Frame-synchronous configuration scheduler for the VGA face streamer.
- Arbitrates face/filter change requests from two requesters: A = audio classifier, B = switches/HPS.
- Holds one pending request and commits it only at an end-of-frame handshake on the pixel stream, so a frame never mixes faces or filters.
- Optional auto mode advances the face every N frames.

---
 rtl/vga_face_pkg.sv | 26 ++
 rtl/vga_face_cfg_sched_rr_arb2.sv | 26 ++
 rtl/vga_face_cfg_sched.sv | 119 +++++++++++
 tb/tb_vga_face_cfg_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_face_pkg.sv
// Shared types and constants for the VGA face configuration scheduler.
package vga_face_pkg;

    localparam int NUM_FACES = 3;

    typedef enum logic [1:0] {
        FACE_WOLF   = 2'd0,
        FACE_P2     = 2'd1,
        FACE_COLOUR = 2'd2
    } face_t;

    localparam logic [3:0] FILTER_NONE     = 4'b0000;
    localparam logic [3:0] FILTER_INVERT   = 4'b0001;
    localparam logic [3:0] FILTER_LIGHTEN  = 4'b0010;
    localparam logic [3:0] FILTER_RED_TINT = 4'b0011;
    localparam logic [3:0] FILTER_DARKEN   = 4'b0100;
    localparam logic [3:0] FILTER_GREY     = 4'b1000;
    localparam logic [3:0] FILTER_BLUR     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

endpackage

// File: rtl/vga_face_cfg_sched_rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the most recently accepted requester.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic valid_a,
    input  logic valid_b,
    input  logic accept,
    output logic grant_a,
    output logic grant_b
);

    // 0 = A was served last, 1 = B was served last
    logic rr_last;

    assign grant_a = valid_a & (!valid_b | rr_last);
    assign grant_b = valid_b & (!valid_a | !rr_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last <= 1'b1;
        end else if (accept) begin
            rr_last <= grant_b;
        end
    end

endmodule

// File: rtl/vga_face_cfg_sched.sv
// Frame-synchronous face/filter scheduler: holds one request and commits it at end of frame.
//   state    | meaning
//   ST_IDLE  | no pending command; auto stepping counts frames here
//   ST_PEND  | a command is held until the next frame end
//   ST_APPLY | single commit cycle, cfg_update high, readies low
module vga_face_cfg_sched #(
    parameter int NUM_FACES = vga_face_pkg::NUM_FACES,
    parameter int FILTER_W  = 4,
    parameter int FCNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_a_valid,
    output logic                req_a_ready,
    input  logic [1:0]          req_a_face,
    input  logic [FILTER_W-1:0] req_a_filter,
    input  logic                req_b_valid,
    output logic                req_b_ready,
    input  logic [1:0]          req_b_face,
    input  logic [FILTER_W-1:0] req_b_filter,
    input  logic                auto_en,
    input  logic [7:0]          auto_period,
    input  logic                st_valid,
    input  logic                st_ready,
    input  logic                st_endofpacket,
    output logic [1:0]          face_select,
    output logic [FILTER_W-1:0] filter_select,
    output logic                cfg_update,
    output logic                pending,
    output logic                bad_req,
    output logic [FCNT_W-1:0]   frame_count
);
    import vga_face_pkg::*;

    state_t              state, state_nx;
    logic                frame_end;
    logic                grant_a, grant_b;
    logic                can_accept, accept, acc_b, face_ok, take_cmd;
    logic [1:0]          sel_face, pend_face, face_next;
    logic [FILTER_W-1:0] sel_filter, pend_filter;
    logic [7:0]          auto_cnt, period_m1;
    logic                auto_hit;

    assign frame_end  = st_valid & st_ready & st_endofpacket;
    // readies are forced low while reset is held, even though state already reads IDLE
    assign can_accept = reset & ((state == ST_IDLE) | ((state == ST_PEND) & !frame_end));
    assign req_a_ready = can_accept & grant_a;
    assign req_b_ready = can_accept & grant_b;

    assign acc_b      = req_b_valid & req_b_ready;
    assign accept     = (req_a_valid & req_a_ready) | acc_b;
    assign sel_face   = acc_b ? req_b_face   : req_a_face;
    assign sel_filter = acc_b ? req_b_filter : req_a_filter;
    assign face_ok    = int'(sel_face) < NUM_FACES;
    assign take_cmd   = accept & face_ok;

    assign period_m1 = (auto_period == 8'd0) ? 8'd0 : auto_period - 8'd1;
    // an external command arriving at the same boundary wins over an auto step
    assign auto_hit  = (state == ST_IDLE) & frame_end & auto_en & (auto_cnt >= period_m1) & !take_cmd;
    assign face_next = (face_select == 2'(NUM_FACES - 1)) ? 2'd0 : face_select + 2'd1;

    assign cfg_update = (state == ST_APPLY);
    assign pending    = (state == ST_PEND);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_a (req_a_valid),
        .valid_b (req_b_valid),
        .accept  (accept),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (take_cmd)      state_nx = ST_PEND;
                else if (auto_hit) state_nx = ST_APPLY;
            end
            ST_PEND:  if (frame_end) state_nx = ST_APPLY;
            ST_APPLY: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            face_select   <= '0;
            filter_select <= '0;
            pend_face     <= '0;
            pend_filter   <= '0;
            bad_req       <= 1'b0;
            frame_count   <= '0;
            auto_cnt      <= '0;
        end else begin
            state <= state_nx;
            if (frame_end) frame_count <= frame_count + {{(FCNT_W-1){1'b0}}, 1'b1};
            if (accept & !face_ok) bad_req <= 1'b1;
            if (take_cmd) begin
                pend_face   <= sel_face;
                pend_filter <= sel_filter;
            end
            if ((state == ST_PEND) & frame_end) begin
                face_select   <= pend_face;
                filter_select <= pend_filter;
                auto_cnt      <= '0;
            end else if (auto_hit) begin
                face_select <= face_next;
                auto_cnt    <= '0;
            end else if ((state == ST_IDLE) & frame_end) begin
                auto_cnt <= (auto_en && auto_cnt < period_m1) ? auto_cnt + 8'd1 : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_face_cfg_sched.sv
// Directed bench for vga_face_cfg_sched: arbitration, frame-synchronous commit, auto cycling, bad codes, reset.
module tb_vga_face_cfg_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a_valid, req_a_ready;
    logic [1:0]  req_a_face;
    logic [3:0]  req_a_filter;
    logic        req_b_valid, req_b_ready;
    logic [1:0]  req_b_face;
    logic [3:0]  req_b_filter;
    logic        auto_en;
    logic [7:0]  auto_period;
    logic        st_valid, st_ready, st_endofpacket;
    logic [1:0]  face_select;
    logic [3:0]  filter_select;
    logic        cfg_update, pending, bad_req;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_fc = 0;

    vga_face_cfg_sched dut (
        .clk            (clk),
        .reset          (reset),
        .req_a_valid    (req_a_valid),
        .req_a_ready    (req_a_ready),
        .req_a_face     (req_a_face),
        .req_a_filter   (req_a_filter),
        .req_b_valid    (req_b_valid),
        .req_b_ready    (req_b_ready),
        .req_b_face     (req_b_face),
        .req_b_filter   (req_b_filter),
        .auto_en        (auto_en),
        .auto_period    (auto_period),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_endofpacket (st_endofpacket),
        .face_select    (face_select),
        .filter_select  (filter_select),
        .cfg_update     (cfg_update),
        .pending        (pending),
        .bad_req        (bad_req),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame();
        st_valid = 1'b1; st_ready = 1'b1; st_endofpacket = 1'b1;
        tick();
        st_valid = 1'b0; st_ready = 1'b0; st_endofpacket = 1'b0;
        exp_fc++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_a_valid = 1'b1; req_a_face = 2'd1; req_a_filter = 4'd1;
        req_b_valid = 1'b1; req_b_face = 2'd1; req_b_filter = 4'd1;
        auto_en = 1'b0; auto_period = 8'd0;
        st_valid = 1'b0; st_ready = 1'b0; st_endofpacket = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_a_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_a: got %b expected 0", req_a_ready); end
        n_cmp++; if (req_b_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_b: got %b expected 0", req_b_ready); end
        n_cmp++; if (face_select !== 2'd0 || filter_select !== 4'd0) begin n_err++; $display("FAIL rst_sel: got %0d/%0h expected 0/0", face_select, filter_select); end
        n_cmp++; if ({cfg_update, pending, bad_req} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b expected 000", {cfg_update, pending, bad_req}); end
        n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rst_fc: got %0d expected 0", frame_count); end
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        reset = 1'b1;
        exp_fc = 0;
    endtask

    task automatic test_basic();
        req_a_valid = 1'b1; req_a_face = 2'd2; req_a_filter = 4'b0001;
        #1;
        n_cmp++; if (req_a_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b expected 1", req_a_ready); end
        tick();
        req_a_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL basic_pending: got %b expected 1", pending); end
        repeat (9) tick();
        n_cmp++; if (face_select !== 2'd0) begin n_err++; $display("FAIL basic_hold: got %0d expected 0", face_select); end
        frame();
        n_cmp++; if (face_select !== 2'd2 || filter_select !== 4'b0001) begin n_err++; $display("FAIL basic_commit: got %0d/%0h expected 2/1", face_select, filter_select); end
        n_cmp++; if (cfg_update !== 1'b1 || pending !== 1'b0) begin n_err++; $display("FAIL basic_upd: got upd=%b pend=%b expected 1/0", cfg_update, pending); end
        n_cmp++; if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL basic_fc: got %0d expected %0d", frame_count, exp_fc); end
        tick();
        n_cmp++; if (cfg_update !== 1'b0) begin n_err++; $display("FAIL basic_upd_width: got %b expected 0", cfg_update); end
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        exp_fc = 0;
        @(negedge clk);
        req_a_valid = 1'b1; req_a_face = 2'd0; req_a_filter = 4'b0011;
        req_b_valid = 1'b1; req_b_face = 2'd1; req_b_filter = 4'b1000;
        #1;
        n_cmp++; if ({req_a_ready, req_b_ready} !== 2'b10) begin n_err++; $display("FAIL rr_first: got %b expected 10", {req_a_ready, req_b_ready}); end
        tick();
        n_cmp++; if ({req_a_ready, req_b_ready} !== 2'b01) begin n_err++; $display("FAIL rr_second: got %b expected 01", {req_a_ready, req_b_ready}); end
        tick();
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        frame();
        n_cmp++; if (face_select !== 2'd1 || filter_select !== 4'b1000) begin n_err++; $display("FAIL rr_held: got %0d/%0h expected 1/8", face_select, filter_select); end
        n_cmp++; if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL rr_fc: got %0d expected %0d", frame_count, exp_fc); end
        tick();
    endtask

    task automatic test_overwrite();
        int ups;
        req_b_valid = 1'b1; req_b_face = 2'd2; req_b_filter = 4'b1111;
        tick();
        req_b_face = 2'd1; req_b_filter = 4'b0101;
        tick();
        req_b_face = 2'd0; req_b_filter = 4'b0010;
        tick();
        req_b_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1 || face_select !== 2'd1) begin n_err++; $display("FAIL ow_pend: got pend=%b face=%0d expected 1/1", pending, face_select); end
        frame();
        ups = int'(cfg_update);
        repeat (4) begin tick(); ups += int'(cfg_update); end
        n_cmp++; if (ups !== 1) begin n_err++; $display("FAIL ow_updates: got %0d expected 1", ups); end
        n_cmp++; if (face_select !== 2'd0 || filter_select !== 4'b0010) begin n_err++; $display("FAIL ow_commit: got %0d/%0h expected 0/2", face_select, filter_select); end
    endtask

    task automatic test_auto();
        logic [1:0] exp_face [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        logic       exp_upd  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] exp_p0   [3] = '{2'd1, 2'd2, 2'd0};
        auto_en = 1'b1; auto_period = 8'd3;
        for (int k = 0; k < 9; k++) begin
            frame();
            n_cmp++; if (face_select !== exp_face[k] || cfg_update !== exp_upd[k]) begin n_err++; $display("FAIL auto3_f%0d: got face=%0d upd=%b expected %0d/%b", k + 1, face_select, cfg_update, exp_face[k], exp_upd[k]); end
            tick();
        end
        auto_period = 8'd0;
        for (int k = 0; k < 3; k++) begin
            frame();
            n_cmp++; if (face_select !== exp_p0[k] || cfg_update !== 1'b1) begin n_err++; $display("FAIL auto0_f%0d: got face=%0d upd=%b expected %0d/1", k + 1, face_select, cfg_update, exp_p0[k]); end
            tick();
        end
        auto_en = 1'b0;
        n_cmp++; if (filter_select !== 4'b0010) begin n_err++; $display("FAIL auto_filter: got %0h expected 2", filter_select); end
        n_cmp++; if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL auto_fc: got %0d expected %0d", frame_count, exp_fc); end
    endtask

    task automatic test_bad_face();
        req_a_valid = 1'b1; req_a_face = 2'd3; req_a_filter = 4'b0111;
        #1;
        n_cmp++; if (req_a_ready !== 1'b1) begin n_err++; $display("FAIL bad_ready: got %b expected 1", req_a_ready); end
        tick();
        req_a_valid = 1'b0;
        n_cmp++; if (bad_req !== 1'b1 || pending !== 1'b0 || face_select !== 2'd0) begin n_err++; $display("FAIL bad_flag: got bad=%b pend=%b face=%0d expected 1/0/0", bad_req, pending, face_select); end
        frame();
        n_cmp++; if (bad_req !== 1'b1 || face_select !== 2'd0 || cfg_update !== 1'b0) begin n_err++; $display("FAIL bad_sticky: got bad=%b face=%0d upd=%b expected 1/0/0", bad_req, face_select, cfg_update); end
    endtask

    task automatic test_collide_and_reset();
        req_a_valid = 1'b1; req_a_face = 2'd1; req_a_filter = 4'b0001;
        tick();
        req_a_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL col_pend: got %b expected 1", pending); end
        req_b_valid = 1'b1; req_b_face = 2'd2; req_b_filter = 4'b0011;
        st_valid = 1'b1; st_ready = 1'b1; st_endofpacket = 1'b1;
        #1;
        n_cmp++; if (req_b_ready !== 1'b0) begin n_err++; $display("FAIL col_ready_fe: got %b expected 0", req_b_ready); end
        tick();
        st_valid = 1'b0; st_ready = 1'b0; st_endofpacket = 1'b0;
        exp_fc++;
        n_cmp++; if (face_select !== 2'd1 || filter_select !== 4'b0001 || cfg_update !== 1'b1) begin n_err++; $display("FAIL col_commit: got %0d/%0h upd=%b expected 1/1/1", face_select, filter_select, cfg_update); end
        n_cmp++; if (req_b_ready !== 1'b0) begin n_err++; $display("FAIL col_ready_apply: got %b expected 0", req_b_ready); end
        tick();
        n_cmp++; if (req_b_ready !== 1'b1 || cfg_update !== 1'b0) begin n_err++; $display("FAIL col_ready_idle: got rdy=%b upd=%b expected 1/0", req_b_ready, cfg_update); end
        tick();
        req_b_valid = 1'b0;
        n_cmp++; if (pending !== 1'b1 || frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL col_later: got pend=%b fc=%0d expected 1/%0d", pending, frame_count, exp_fc); end
        #2;
        req_a_valid = 1'b1;
        reset = 1'b0;
        #1;
        n_cmp++; if ({pending, cfg_update, bad_req} !== 3'b000 || face_select !== 2'd0 || filter_select !== 4'd0) begin n_err++; $display("FAIL rst_async: got flags=%b face=%0d filt=%0h expected 000/0/0", {pending, cfg_update, bad_req}, face_select, filter_select); end
        n_cmp++; if (frame_count !== 16'd0 || req_a_ready !== 1'b0) begin n_err++; $display("FAIL rst_async_fc: got fc=%0d rdy=%b expected 0/0", frame_count, req_a_ready); end
        @(negedge clk);
        req_a_valid = 1'b0;
        reset = 1'b1;
        exp_fc = 0;
        frame();
        n_cmp++; if (face_select !== 2'd0 || pending !== 1'b0 || cfg_update !== 1'b0) begin n_err++; $display("FAIL rst_discard: got face=%0d pend=%b upd=%b expected 0/0/0", face_select, pending, cfg_update); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_overwrite();
        test_auto();
        test_bad_face();
        test_collide_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
